// File: rtl/axi_mem_responder.sv
// AXI4 responder terminating an ariane_axi req/resp pair with a flop-based
// 64-bit scratchpad; independent read and write FSMs with burst support.
package ariane_axi;

    typedef logic [3:0]  id_t;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  strb_t;
    typedef logic [0:0]  user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

module axi_mem_responder
    import ariane_axi::*;
#(
    parameter int unsigned NumWords = 256,
    parameter logic [63:0] BaseAddr = 64'h0
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  axi_req_i,
    output resp_t axi_resp_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam logic [63:0] Span = 64'(NumWords) << 3;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    function automatic logic [63:0] next_addr(
        input logic [63:0] a,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        step = 64'd1 << size;
        if (burst == BurstFixed) begin
            return a;
        end
        return (a & ~(step - 64'd1)) + step;
    endfunction

    logic [1:0]  w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [63:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [2:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic        w_err_q, w_err_d;

    logic [0:0]  r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [63:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [2:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic [7:0]  r_cnt_q, r_cnt_d;

    logic [NumWords-1:0][63:0] mem_q;

    logic [63:0]     wr_off, rd_off;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic            wr_in_range, rd_in_range;
    logic            w_last_beat, r_last_beat;
    logic            r_err;
    logic            mem_we;
    logic            unused_req;

    assign wr_off      = w_addr_q - BaseAddr;
    assign rd_off      = r_addr_q - BaseAddr;
    assign wr_idx      = wr_off[IdxW+2:3];
    assign rd_idx      = rd_off[IdxW+2:3];
    // Subtracting the base first makes addresses below it wrap to huge offsets.
    assign wr_in_range = wr_off < Span;
    assign rd_in_range = rd_off < Span;
    assign w_last_beat = w_cnt_q == w_len_q;
    assign r_last_beat = r_cnt_q == r_len_q;
    assign r_err       = !rd_in_range || r_burst_q[1];
    assign unused_req  = ^axi_req_i;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (axi_req_i.aw_valid) begin
                    w_id_d    = axi_req_i.aw.id;
                    w_addr_d  = axi_req_i.aw.addr;
                    w_len_d   = axi_req_i.aw.len;
                    w_size_d  = axi_req_i.aw.size;
                    w_burst_d = axi_req_i.aw.burst;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_req_i.w_valid) begin
                    if (!wr_in_range || w_burst_q[1]) begin
                        w_err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                    if (axi_req_i.w.last != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_req_i.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (axi_req_i.ar_valid) begin
                    r_id_d    = axi_req_i.ar.id;
                    r_addr_d  = axi_req_i.ar.addr;
                    r_len_d   = axi_req_i.ar.len;
                    r_size_d  = axi_req_i.ar.size;
                    r_burst_d = axi_req_i.ar.burst;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_req_i.r_ready) begin
                    r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
                    r_cnt_d  = r_cnt_q + 8'd1;
                    if (r_last_beat) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (axi_req_i.w.strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
                end
            end
        end
    end

    // Everything is forced low while reset is held, including the IDLE readies.
    always_comb begin
        axi_resp_o = '0;
        if (rst_ni) begin
            axi_resp_o.aw_ready = w_state_q == W_IDLE;
            axi_resp_o.w_ready  = w_state_q == W_DATA;
            axi_resp_o.b_valid  = w_state_q == W_RESP;
            axi_resp_o.b.id     = w_id_q;
            axi_resp_o.b.resp   = w_err_q ? RespSlvErr : RespOkay;
            axi_resp_o.ar_ready = r_state_q == R_IDLE;
            axi_resp_o.r_valid  = r_state_q == R_DATA;
            axi_resp_o.r.id     = r_id_q;
            axi_resp_o.r.data   = r_err ? 64'h0 : mem_q[rd_idx];
            axi_resp_o.r.resp   = r_err ? RespSlvErr : RespOkay;
            axi_resp_o.r.last   = (r_state_q == R_DATA) && r_last_beat;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: write/read transactions driven
// by tasks, read beats collected and compared against pushed expectations.
module tb_axi_mem_responder;
    import ariane_axi::*;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] SLV   = 2'b10;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    req_t  req;
    resp_t resp;

    int checks = 0;
    int errors = 0;

    logic [63:0] wd [16];
    logic [70:0] exp_q [$];
    logic [70:0] obs_q [$];
    int          unstable;
    logic        rd_timeout;
    logic        wr_timeout;
    logic [1:0]  b_resp_o;
    logic [3:0]  b_id_o;
    int          w_beats;
    int          w_stall;
    int          b_wait;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .NumWords(256),
        .BaseAddr(64'h0)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    function automatic logic [70:0] beat(
        input logic [3:0] id, input logic last,
        input logic [1:0] rsp, input logic [63:0] d
    );
        return {id, last, rsp, d};
    endfunction

    task automatic wr(
        input logic [3:0] id, input logic [63:0] addr, input int len,
        input logic [1:0] burst, input logic [7:0] strb, input bit bad_last
    );
        int n;
        wr_timeout = 0; w_beats = 0; w_stall = 0; b_wait = 0;
        req.aw = '0;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = 8'(len);
        req.aw.size = 3'd3; req.aw.burst = burst;
        req.aw_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp.aw_ready && n < 50);
        if (!resp.aw_ready) wr_timeout = 1;
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            req.w.data = wd[i];
            req.w.strb = strb;
            req.w.last = (i == len) || (bad_last && i == 0);
            req.w_valid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!resp.w_ready && n < 50);
            if (!resp.w_ready) wr_timeout = 1;
            w_stall += n - 1;
            w_beats++;
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp.b_valid && n < 50);
        if (!resp.b_valid) wr_timeout = 1;
        b_wait = n - 1;
        b_resp_o = resp.b.resp;
        b_id_o = resp.b.id;
        @(posedge clk); #1;
        req.b_ready = 1'b0;
    endtask

    task automatic rd(
        input logic [3:0] id, input logic [63:0] addr, input int len,
        input logic [1:0] burst, input bit toggle
    );
        logic [70:0] prev, cur;
        bit have_prev, done;
        int n;
        obs_q.delete();
        unstable = 0; rd_timeout = 0; have_prev = 0; done = 0;
        req.ar = '0;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = 8'(len);
        req.ar.size = 3'd3; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp.ar_ready && n < 50);
        if (!resp.ar_ready) rd_timeout = 1;
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            req.r_ready = toggle ? (c % 2 == 1) : 1'b1;
            @(negedge clk);
            if (resp.r_valid) begin
                cur = {resp.r.id, resp.r.last, resp.r.resp, resp.r.data};
                if (have_prev && cur !== prev) unstable++;
                if (req.r_ready) begin
                    obs_q.push_back(cur);
                    have_prev = 0;
                    done = resp.r.last;
                end else begin
                    prev = cur;
                    have_prev = 1;
                end
            end
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        if (!done) rd_timeout = 1;
    endtask

    task automatic test_reset;
        logic [70:0] e, o;
        #1;
        checks++;
        if (resp !== '0) begin
            errors++;
            $display("FAIL rst_outputs got %h want 0", resp);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp.aw_ready, resp.ar_ready, resp.b_valid, resp.r_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_ready got %b want 1100",
                     {resp.aw_ready, resp.ar_ready, resp.b_valid, resp.r_valid});
        end
        @(posedge clk); #1;
        exp_q.push_back(beat(4'd0, 1'b1, OKAY, 64'h0));
        rd(4'd0, 64'h0, 0, INCR, 0);
        checks++;
        if (rd_timeout || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_rd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_rd_beat got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_single_write;
        logic [70:0] e, o;
        wd[0] = 64'hDEAD_BEEF_0123_4567;
        wr(4'd1, 64'h10, 0, INCR, 8'h0F, 0);
        checks++;
        if (wr_timeout || b_resp_o !== OKAY || b_id_o !== 4'd1) begin
            errors++;
            $display("FAIL single_b got resp %b id %h to %0d want 00 1 0",
                     b_resp_o, b_id_o, wr_timeout);
        end
        checks++;
        if (w_stall != 0 || b_wait != 0) begin
            errors++;
            $display("FAIL single_latency got wstall %0d bwait %0d want 0 0",
                     w_stall, b_wait);
        end
        exp_q.push_back(beat(4'd9, 1'b1, OKAY, 64'h0000_0000_0123_4567));
        rd(4'd9, 64'h10, 0, INCR, 0);
        checks++;
        if (rd_timeout || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_rd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_rd_beat got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_incr_burst;
        logic [70:0] e, o;
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        wr(4'd2, 64'h20, 3, INCR, 8'hFF, 0);
        checks++;
        if (wr_timeout || b_resp_o !== OKAY || w_beats != 4) begin
            errors++;
            $display("FAIL incr_wr got resp %b beats %0d want 00 4", b_resp_o, w_beats);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(beat(4'd3, i == 3, OKAY, 64'(i + 1)));
        end
        rd(4'd3, 64'h20, 3, INCR, 1);
        checks++;
        if (rd_timeout || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL incr_rd_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL incr_stall_stable got %0d changes want 0", unstable);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL incr_rd_beat got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_oob_wrap;
        logic [70:0] e, o;
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(4'd4, 64'h800, 0, INCR, 8'hFF, 0);
        checks++;
        if (wr_timeout || b_resp_o !== SLV) begin
            errors++;
            $display("FAIL oob_wr got %b want 10", b_resp_o);
        end
        wd[0] = 64'h1111_1111_1111_1111;
        wd[1] = 64'h2222_2222_2222_2222;
        wr(4'd5, 64'h10, 1, WRAP, 8'hFF, 0);
        checks++;
        if (wr_timeout || b_resp_o !== SLV || w_beats != 2) begin
            errors++;
            $display("FAIL wrap_wr got %b beats %0d want 10 2", b_resp_o, w_beats);
        end
        exp_q.push_back(beat(4'd6, 1'b1, OKAY, 64'h0));
        exp_q.push_back(beat(4'd6, 1'b1, OKAY, 64'h0000_0000_0123_4567));
        exp_q.push_back(beat(4'd6, 1'b1, SLV, 64'h0));
        rd(4'd6, 64'h0, 0, INCR, 0);
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        checks++;
        if (rd_timeout || o !== e) begin
            errors++;
            $display("FAIL oob_mem_alias got %h want %h", o, e);
        end
        rd(4'd6, 64'h10, 0, INCR, 0);
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        checks++;
        if (rd_timeout || o !== e) begin
            errors++;
            $display("FAIL wrap_no_write got %h want %h", o, e);
        end
        rd(4'd6, 64'h800, 0, INCR, 0);
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        checks++;
        if (rd_timeout || o !== e) begin
            errors++;
            $display("FAIL oob_rd got %h want %h", o, e);
        end
        rd(4'd7, 64'h20, 1, WRAP, 0);
        checks++;
        if (rd_timeout || obs_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_rd_count got %0d want 2", obs_q.size());
        end
        for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            checks++;
            if (o[70:64] !== {4'd7, i == 1, SLV}) begin
                errors++;
                $display("FAIL wrap_rd_beat got %h want %h", o[70:64], {4'd7, i == 1, SLV});
            end
        end
    endtask

    task automatic test_wlast_mismatch;
        wd[0] = 64'h5;
        wd[1] = 64'h6;
        wr(4'd5, 64'h40, 1, INCR, 8'hFF, 1);
        checks++;
        if (wr_timeout || w_beats != 2 || b_resp_o !== SLV) begin
            errors++;
            $display("FAIL wlast got beats %0d resp %b want 2 10", w_beats, b_resp_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [70:0] o, e;
        req.aw = '0;
        req.aw.id = 4'd6; req.aw.addr = 64'h48; req.aw.size = 3'd3; req.aw.burst = INCR;
        req.ar = '0;
        req.ar.id = 4'd7; req.ar.addr = 64'h28; req.ar.size = 3'd3; req.ar.burst = INCR;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp.aw_ready, resp.ar_ready} !== 2'b11) begin
            errors++;
            $display("FAIL conc_ready got %b want 11", {resp.aw_ready, resp.ar_ready});
        end
        @(posedge clk); #1;
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        req.w.data = 64'hA5A5_5A5A_0F0F_F0F0;
        req.w.strb = 8'hFF;
        req.w.last = 1'b1;
        req.w_valid = 1'b1;
        req.r_ready = 1'b1;
        req.b_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp.w_ready, resp.r_valid, resp.aw_ready, resp.ar_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL conc_busy got %b want 1100",
                     {resp.w_ready, resp.r_valid, resp.aw_ready, resp.ar_ready});
        end
        o = {resp.r.id, resp.r.last, resp.r.resp, resp.r.data};
        e = beat(4'd7, 1'b1, OKAY, 64'h2);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL conc_rd got %h want %h", o, e);
        end
        @(posedge clk); #1;
        req.w_valid = 1'b0;
        req.r_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp.b_valid, resp.b.resp, resp.b.id, resp.r_valid} !== {1'b1, OKAY, 4'd6, 1'b0}) begin
            errors++;
            $display("FAIL conc_b got %b want %b",
                     {resp.b_valid, resp.b.resp, resp.b.id, resp.r_valid},
                     {1'b1, OKAY, 4'd6, 1'b0});
        end
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        exp_q.push_back(beat(4'd8, 1'b1, OKAY, 64'hA5A5_5A5A_0F0F_F0F0));
        rd(4'd8, 64'h48, 0, INCR, 0);
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        checks++;
        if (rd_timeout || o !== e) begin
            errors++;
            $display("FAIL conc_readback got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [70:0] o, e;
        req.ar = '0;
        req.ar.id = 4'd8; req.ar.addr = 64'h20; req.ar.len = 8'd3;
        req.ar.size = 3'd3; req.ar.burst = INCR;
        req.ar_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        req.r_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (resp.r_valid !== 1'b1 || resp.r.data !== 64'h2) begin
            errors++;
            $display("FAIL mid_beat2 got v %b d %h want 1 2", resp.r_valid, resp.r.data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp !== '0) begin
            errors++;
            $display("FAIL mid_rst_outputs got %h want 0", resp);
        end
        req.r_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp.ar_ready, resp.aw_ready, resp.r_valid, resp.b_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_idle got %b want 1100",
                     {resp.ar_ready, resp.aw_ready, resp.r_valid, resp.b_valid});
        end
        @(posedge clk); #1;
        exp_q.push_back(beat(4'd9, 1'b1, OKAY, 64'h0));
        rd(4'd9, 64'h20, 0, INCR, 0);
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        checks++;
        if (rd_timeout || o !== e) begin
            errors++;
            $display("FAIL mid_mem_clear got %h want %h", o, e);
        end
    endtask

    initial begin
        req = '0;
        test_reset();
        test_single_write();
        test_incr_burst();
        test_oob_wrap();
        test_wlast_mismatch();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
